// File: rtl/syncv_param_pkg.sv
// Shared defaults for the vertical sync generator: frame periods, blank/sync
// line numbers and the per-mode pixel window table.
package syncv_param_pkg;

    localparam int unsigned VW_DEF          = 9;
    localparam int unsigned PERIOD_PENTAGON = 320;
    localparam int unsigned PERIOD_128K     = 312;
    localparam int unsigned VBLNK_BEG_DEF   = 0;
    localparam int unsigned VSYNC_BEG_DEF   = 8;
    localparam int unsigned VSYNC_END_DEF   = 11;
    localparam int unsigned VBLNK_END_DEF   = 32;
    localparam int unsigned INT_BEG_DEF     = 0;
    localparam int unsigned FRAME_CW        = 5;
    localparam int unsigned PIX_LW          = 8;

    typedef struct packed {
        logic [15:0] beg;
        logic [15:0] fin;
    } win_t;

    // Pixel window (set line, clear line) selected by the latched mode.
    function automatic win_t mode_win(input logic [1:0] mode);
        win_t w;
        case (mode)
            2'd0:    w = '{beg: 16'd80, fin: 16'd272};
            2'd1:    w = '{beg: 16'd76, fin: 16'd276};
            2'd2:    w = '{beg: 16'd56, fin: 16'd296};
            default: w = '{beg: 16'd48, fin: 16'd304};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/syncv_win.sv
// Line window flag: set when vcount equals set_line on set_stb, cleared when
// vcount equals clr_line on clr_stb; set has priority.
module syncv_win
    import syncv_param_pkg::*;
#(
    parameter int unsigned VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_stb,
    input  logic          clr_stb,
    input  logic [VW-1:0] vcount,
    input  logic [VW-1:0] set_line,
    input  logic [VW-1:0] clr_line,
    output logic          win
);

    logic win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (set_stb && (vcount == set_line)) begin
            win_d = 1'b1;
        end else if (clr_stb && (vcount == clr_line)) begin
            win_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= 1'b0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win = win_q;

endmodule

// File: rtl/syncv_param.sv
// Vertical timing generator: line counter, blank/sync/pixel windows, INT and flash.
// Define SYNCV_LINEINT_EN to add the programmable raster-line interrupt.
module syncv_param
    import syncv_param_pkg::*;
#(
    parameter int unsigned VW        = VW_DEF,
    parameter int unsigned PERIOD_0  = PERIOD_PENTAGON,
    parameter int unsigned PERIOD_1  = PERIOD_128K,
    parameter int unsigned VBLNK_BEG = VBLNK_BEG_DEF,
    parameter int unsigned VSYNC_BEG = VSYNC_BEG_DEF,
    parameter int unsigned VSYNC_END = VSYNC_END_DEF,
    parameter int unsigned VBLNK_END = VBLNK_END_DEF,
    parameter int unsigned INT_BEG   = INT_BEG_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync_start,
    input  logic          line_start,
    input  logic          hint_start,
    input  logic [1:0]    mode,
    input  logic          per_sel,
    output logic          vblank,
    output logic          vsync,
    output logic          vpix,
    output logic          int_start,
    output logic          frame_start,
    output logic [VW-1:0] vcount,
    output logic [7:0]    vpix_line,
    output logic          flash
`ifdef SYNCV_LINEINT_EN
    ,
    input  logic [VW-1:0] line_int_num,
    output logic          line_int_start
`endif
);

    logic [VW-1:0]       vcount_q, vcount_d;
    logic [1:0]          mode_q, mode_d;
    logic                per_q, per_d;
    logic [FRAME_CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [PIX_LW-1:0]   vpix_line_q, vpix_line_d;
    logic                int_start_q, int_start_d;
    logic                frame_start_q, frame_start_d;
    logic [VW-1:0]       period_m1;
    logic [VW-1:0]       pix_beg, pix_end;
    logic                wrap;
    win_t                pix_win;

    // Line counter; period and mode only change at the frame wrap.
    always_comb begin
        period_m1     = per_q ? VW'(PERIOD_1 - 1) : VW'(PERIOD_0 - 1);
        wrap          = hsync_start && (vcount_q == period_m1);
        vcount_d      = vcount_q;
        mode_d        = mode_q;
        per_d         = per_q;
        frame_cnt_d   = frame_cnt_q;
        if (hsync_start) begin
            vcount_d = wrap ? '0 : vcount_q + VW'(1);
        end
        if (wrap) begin
            mode_d      = mode;
            per_d       = per_sel;
            frame_cnt_d = frame_cnt_q + FRAME_CW'(1);
        end
        frame_start_d = wrap;
        int_start_d   = hint_start && (vcount_q == VW'(INT_BEG));
    end

    // Pixel line index tracks the vpix window; the clearing strobe holds the last index.
    always_comb begin
        pix_win     = mode_win(mode_q);
        pix_beg     = VW'(pix_win.beg);
        pix_end     = VW'(pix_win.fin);
        vpix_line_d = vpix_line_q;
        if (hsync_start) begin
            if (vcount_q == pix_beg) begin
                vpix_line_d = '0;
            end else if (vpix && (vcount_q != pix_end) && (vpix_line_q != '1)) begin
                vpix_line_d = vpix_line_q + PIX_LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcount_q      <= '0;
            mode_q        <= '0;
            per_q         <= 1'b0;
            frame_cnt_q   <= '0;
            vpix_line_q   <= '0;
            int_start_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            mode_q        <= mode_d;
            per_q         <= per_d;
            frame_cnt_q   <= frame_cnt_d;
            vpix_line_q   <= vpix_line_d;
            int_start_q   <= int_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    syncv_win #(.VW(VW)) u_vblank (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_stb  (hsync_start),
        .clr_stb  (hsync_start),
        .vcount   (vcount_q),
        .set_line (VW'(VBLNK_BEG)),
        .clr_line (VW'(VBLNK_END)),
        .win      (vblank)
    );

    // vsync opens on a line advance but closes on the mid-line strobe.
    syncv_win #(.VW(VW)) u_vsync (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_stb  (hsync_start),
        .clr_stb  (line_start),
        .vcount   (vcount_q),
        .set_line (VW'(VSYNC_BEG)),
        .clr_line (VW'(VSYNC_END)),
        .win      (vsync)
    );

    syncv_win #(.VW(VW)) u_vpix (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_stb  (hsync_start),
        .clr_stb  (hsync_start),
        .vcount   (vcount_q),
        .set_line (pix_beg),
        .clr_line (pix_end),
        .win      (vpix)
    );

    assign vcount      = vcount_q;
    assign vpix_line   = vpix_line_q;
    assign int_start   = int_start_q;
    assign frame_start = frame_start_q;
    assign flash       = frame_cnt_q[FRAME_CW-1];

`ifdef SYNCV_LINEINT_EN
    logic line_int_start_q, line_int_start_d;

    // Targets beyond the current period can never match a live line.
    always_comb begin
        line_int_start_d = hint_start && (vcount_q == line_int_num) &&
                           (line_int_num <= period_m1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_int_start_q <= 1'b0;
        end else begin
            line_int_start_q <= line_int_start_d;
        end
    end

    assign line_int_start = line_int_start_q;
`endif

endmodule

// File: tb/tb_syncv_param.sv
// Self-checking bench for syncv_param against a line-level reference model.
// Line-interrupt checks are compiled in when SYNCV_LINEINT_EN is defined.
module tb_syncv_param;

    localparam int unsigned VW = 9;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          hsync_start = 1'b0;
    logic          line_start  = 1'b0;
    logic          hint_start  = 1'b0;
    logic [1:0]    mode        = 2'd0;
    logic          per_sel     = 1'b0;
    logic          vblank, vsync, vpix, int_start, frame_start, flash;
    logic [VW-1:0] vcount;
    logic [7:0]    vpix_line;
`ifdef SYNCV_LINEINT_EN
    logic [VW-1:0] line_int_num = '0;
    logic          line_int_start;
    bit            e_lint;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: current line, frame length, latched mode, frame count.
    int m_line, m_per, m_mode, m_frames, m_hold;
    bit m_vs, e_int, e_frame;

    always #5 clk = ~clk;

    syncv_param dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hsync_start    (hsync_start),
        .line_start     (line_start),
        .hint_start     (hint_start),
        .mode           (mode),
        .per_sel        (per_sel),
        .vblank         (vblank),
        .vsync          (vsync),
        .vpix           (vpix),
        .int_start      (int_start),
        .frame_start    (frame_start),
        .vcount         (vcount),
        .vpix_line      (vpix_line),
        .flash          (flash)
`ifdef SYNCV_LINEINT_EN
        ,
        .line_int_num   (line_int_num),
        .line_int_start (line_int_start)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int win_lo(input int m);
        case (m)
            0: return 80;
            1: return 76;
            2: return 56;
            default: return 48;
        endcase
    endfunction

    function automatic int win_hi(input int m);
        case (m)
            0: return 272;
            1: return 276;
            2: return 296;
            default: return 304;
        endcase
    endfunction

    // Flags become visible on the line after their set/clear strobe.
    function automatic bit exp_vblank();
        return (m_line >= 1) && (m_line <= 32);
    endfunction

    function automatic bit exp_vpix();
        return (m_line > win_lo(m_mode)) && (m_line <= win_hi(m_mode));
    endfunction

    function automatic int exp_vline();
        int v;
        if (!exp_vpix()) return m_hold;
        v = m_line - win_lo(m_mode) - 1;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic bit exp_flash();
        return (m_frames % 32) >= 16;
    endfunction

    task automatic model_reset();
        m_line = 0; m_per = 320; m_mode = 0; m_frames = 0; m_hold = 0;
        m_vs = 1'b0; e_int = 1'b0; e_frame = 1'b0;
`ifdef SYNCV_LINEINT_EN
        e_lint = 1'b0;
`endif
    endtask

    // One clock with the given strobes; model advanced alongside.
    task automatic step(input bit h, input bit l, input bit hi);
        int pre;
        bit wr;
        pre = m_line;
        hsync_start = h; line_start = l; hint_start = hi;
        wr      = h && (pre == m_per - 1);
        e_int   = hi && (pre == 0);
        e_frame = wr;
`ifdef SYNCV_LINEINT_EN
        e_lint  = hi && (pre == int'(line_int_num));
`endif
        if (h && pre == 8) m_vs = 1'b1;
        else if (l && pre == 11) m_vs = 1'b0;
        if (h) begin
            m_line = wr ? 0 : pre + 1;
            if (wr) begin
                m_per  = per_sel ? 312 : 320;
                m_mode = int'(mode);
                m_frames++;
            end
        end
        @(negedge clk);
        hsync_start = 1'b0; line_start = 1'b0; hint_start = 1'b0;
        if (exp_vpix()) m_hold = exp_vline();
    endtask

    task automatic rnd_cycle(output bit h, input int hp);
        bit l, hi;
        h  = ($urandom_range(0, hp - 1) == 0);
        l  = ($urandom_range(0, 3) == 0);
        hi = ($urandom_range(0, 5) == 0);
        step(h, l, hi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hsync_start = 1'b0; line_start = 1'b0; hint_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd0; per_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        checks++;
        if (vcount !== '0) begin errors++; $display("FAIL reset_vcount got=%0d want=0", vcount); end
        checks++;
        if ({vblank, vsync, vpix, int_start, frame_start, flash} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=000000", {vblank, vsync, vpix, int_start, frame_start, flash});
        end
        checks++;
        if (vpix_line !== 8'd0) begin errors++; $display("FAIL reset_vpix_line got=%0d want=0", vpix_line); end
`ifdef SYNCV_LINEINT_EN
        checks++;
        if (line_int_start !== 1'b0) begin errors++; $display("FAIL reset_line_int got=%b want=0", line_int_start); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (vblank !== 1'b1) begin errors++; $display("FAIL first_line_vblank got=%b want=1", vblank); end
        checks++;
        if (vcount !== VW'(1)) begin errors++; $display("FAIL first_line_vcount got=%0d want=1", vcount); end
    endtask

    task automatic test_frame_wrap();
        bit h;
        int hs_since = 0, pulses = 0, budget = 0;
        bit seen_last = 1'b0;
        per_sel = 1'b0; mode = 2'($urandom_range(0, 3));
        do_reset();
        while (pulses < 2 && budget < 8000) begin
            rnd_cycle(h, 3);
            budget++;
            if (h) hs_since++;
            checks++;
            if (vcount !== VW'(m_line)) begin errors++; $display("FAIL wrap_vcount got=%0d want=%0d", vcount, m_line); end
            checks++;
            if (vblank !== exp_vblank()) begin errors++; $display("FAIL wrap_vblank line=%0d got=%b want=%b", m_line, vblank, exp_vblank()); end
            checks++;
            if (frame_start !== e_frame) begin errors++; $display("FAIL wrap_frame_start got=%b want=%b", frame_start, e_frame); end
            if (vcount == VW'(319)) seen_last = 1'b1;
            if (frame_start === 1'b1) begin
                pulses++;
                checks++;
                if (hs_since != 320) begin errors++; $display("FAIL wrap_frame_len got=%0d want=320", hs_since); end
                hs_since = 0;
            end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL wrap_pulses got=%0d want=2", pulses); end
        checks++;
        if (seen_last !== 1'b1) begin errors++; $display("FAIL wrap_line319 got=%b want=1", seen_last); end
    endtask

    task automatic test_vsync();
        int budget = 0;
        do_reset();
        while (m_line < 14 && budget < 100) begin
            budget++;
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (vsync !== m_vs) begin errors++; $display("FAIL vsync_line%0d got=%b want=%b", m_line, vsync, m_vs); end
            if (m_line == 9 || m_line == 11) begin
                step(1'b0, 1'b1, 1'b0);
                checks++;
                if (vsync !== (m_line == 9)) begin
                    errors++; $display("FAIL vsync_ls_line%0d got=%b want=%b", m_line, vsync, (m_line == 9));
                end
                if (m_line == 11) begin
                    step(1'b0, 1'b1, 1'b0);
                    checks++;
                    if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_second_ls got=%b want=0", vsync); end
                end
            end
        end
    endtask

    task automatic test_vpix_mode();
        bit h;
        int budget = 0, n2 = 0, n3 = 0, max2 = 0, first2 = -1;
        mode = 2'd2; per_sel = 1'b0;
        do_reset();
        while (!(m_frames >= 2 && m_line >= 280) && budget < 12000) begin
            budget++;
            if (m_frames == 1 && m_line == 100) mode = 2'd0;
            rnd_cycle(h, 2);
            checks++;
            if (vpix !== exp_vpix()) begin errors++; $display("FAIL vpix line=%0d got=%b want=%b", m_line, vpix, exp_vpix()); end
            checks++;
            if (vpix_line !== 8'(exp_vline())) begin
                errors++; $display("FAIL vpix_line line=%0d got=%0d want=%0d", m_line, vpix_line, exp_vline());
            end
            if (h && vpix === 1'b1) begin
                if (m_frames == 1) begin
                    n2++;
                    if (int'(vpix_line) > max2) max2 = int'(vpix_line);
                    if (first2 < 0) first2 = m_line;
                end else if (m_frames == 2) begin
                    n3++;
                end
            end
        end
        checks++;
        if (n2 != 240) begin errors++; $display("FAIL vpix_mode2_lines got=%0d want=240", n2); end
        checks++;
        if (max2 != 239) begin errors++; $display("FAIL vpix_mode2_last got=%0d want=239", max2); end
        checks++;
        if (first2 != 57) begin errors++; $display("FAIL vpix_mode2_first got=%0d want=57", first2); end
        checks++;
        if (n3 != 192) begin errors++; $display("FAIL vpix_mode0_lines got=%0d want=192", n3); end
    endtask

    task automatic test_period_switch();
        bit h;
        int budget = 0, nfs = 0, hs = 0, pulses = 0;
        int lens[2];
        lens[0] = 0; lens[1] = 0;
        per_sel = 1'b0; mode = 2'd0;
        do_reset();
        while (nfs < 2 && budget < 12000) begin
            budget++;
            if (m_frames == 0 && m_line == 150) per_sel = 1'b1;
            rnd_cycle(h, 2);
            if (h) hs++;
            checks++;
            if (vcount !== VW'(m_line)) begin errors++; $display("FAIL per_vcount got=%0d want=%0d", vcount, m_line); end
            checks++;
            if (int_start !== e_int) begin errors++; $display("FAIL per_int_start got=%b want=%b", int_start, e_int); end
            checks++;
            if (frame_start !== e_frame) begin errors++; $display("FAIL per_frame_start got=%b want=%b", frame_start, e_frame); end
            if (frame_start === 1'b1) begin
                lens[nfs] = hs; hs = 0; nfs++;
            end
        end
        checks++;
        if (lens[0] != 320) begin errors++; $display("FAIL per_len0 got=%0d want=320", lens[0]); end
        checks++;
        if (lens[1] != 312) begin errors++; $display("FAIL per_len1 got=%0d want=312", lens[1]); end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (int_start !== 1'b1) begin errors++; $display("FAIL int_pulse got=%b want=1", int_start); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (int_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL int_pulse_width extra=%0d want=0", pulses); end
    endtask

    task automatic test_line_int();
        int budget = 0, n_int = 0;
`ifdef SYNCV_LINEINT_EN
        int n_lint = 0;
        line_int_num = VW'(150);
`endif
        per_sel = 1'b1; mode = 2'd0;
        do_reset();
        while (m_frames < 2 && budget < 4000) begin
            budget++;
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (int_start !== e_int) begin errors++; $display("FAIL lint_int_start got=%b want=%b", int_start, e_int); end
            if (int_start === 1'b1) n_int++;
`ifdef SYNCV_LINEINT_EN
            checks++;
            if (line_int_start !== e_lint) begin
                errors++; $display("FAIL line_int line=%0d got=%b want=%b", m_line, line_int_start, e_lint);
            end
            if (line_int_start === 1'b1) n_lint++;
`endif
        end
        checks++;
        if (n_int != 2) begin errors++; $display("FAIL int_per_frame got=%0d want=2", n_int); end
`ifdef SYNCV_LINEINT_EN
        checks++;
        if (n_lint != 2) begin errors++; $display("FAIL line_int_count got=%0d want=2", n_lint); end
        line_int_num = VW'(400); n_lint = 0; budget = 0;
        while (m_frames < 3 && budget < 4000) begin
            budget++;
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (line_int_start !== e_lint) begin errors++; $display("FAIL line_int_400 got=%b want=%b", line_int_start, e_lint); end
            if (line_int_start === 1'b1) n_lint++;
        end
        checks++;
        if (n_lint != 0) begin errors++; $display("FAIL line_int_400_count got=%0d want=0", n_lint); end
`endif
    endtask

    task automatic test_reset_midframe();
        int budget = 0, flash_rise = -1;
        per_sel = 1'b0; mode = 2'd0;
        do_reset();
        while (m_line < 200 && budget < 1000) begin
            budget++;
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        checks++;
        if (vpix !== 1'b1) begin errors++; $display("FAIL mid_vpix_before got=%b want=1", vpix); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vcount !== '0) begin errors++; $display("FAIL mid_reset_vcount got=%0d want=0", vcount); end
        checks++;
        if ({vblank, vsync, vpix, int_start, frame_start, flash} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_flags got=%b want=000000", {vblank, vsync, vpix, int_start, frame_start, flash});
        end
        checks++;
        if (vpix_line !== 8'd0) begin errors++; $display("FAIL mid_reset_vpix_line got=%0d want=0", vpix_line); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (vcount !== VW'(1) || vblank !== 1'b1) begin
            errors++; $display("FAIL mid_restart got vcount=%0d vblank=%b want 1/1", vcount, vblank);
        end
        budget = 0;
        while (m_frames < 17 && budget < 8000) begin
            budget++;
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (flash !== exp_flash()) begin errors++; $display("FAIL flash frame=%0d got=%b want=%b", m_frames, flash, exp_flash()); end
            if (flash === 1'b1 && flash_rise < 0) flash_rise = m_frames;
        end
        checks++;
        if (flash_rise != 16) begin errors++; $display("FAIL flash_rise_frame got=%0d want=16", flash_rise); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame_wrap();
        test_vsync();
        test_vpix_mode();
        test_period_switch();
        test_line_int();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
